// File: rtl/param_datapath.sv
// param_datapath: register-file datapath with single-cycle ALU ops,
// iterative shift-add multiply and restoring divide, and a program counter.
module param_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [AW-1:0]    A,
    input  logic [AW-1:0]    C,
    input  logic [AW-1:0]    Y1,
    input  logic [AW-1:0]    Y2,
    input  logic [1:0]       write,
    input  logic             const_c,
    input  logic [WIDTH-1:0] constant,
    input  logic             pc_inc,
    input  logic             jump,
    output logic             ready,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] st_data,
    output logic [WIDTH-1:0] program_counter
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_COPY = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

    // Register file; entry 0 is only ever cleared, so it always reads zero.
    logic [WIDTH-1:0] r_regs [NREGS];
    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    // Shared iteration registers: r_lo ends as result1, r_hi as result2.
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic             r_is_div;
    logic             r_div0_pend;
    logic [1:0]       r_wr;
    logic [AW-1:0]    r_y1;
    logic [AW-1:0]    r_y2;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_pc;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_alu;
    logic             w_issue;
    logic             w_issue_long;
    logic             w_issue_single;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_trial;
    logic             w_fits;
    logic             w_we1;
    logic             w_we2;
    logic [AW-1:0]    w_wa1;
    logic [AW-1:0]    w_wa2;
    logic [WIDTH-1:0] w_res1;
    logic [WIDTH-1:0] w_res2;

    assign w_a      = r_regs[A];
    assign w_b      = const_c ? constant : r_regs[C];
    assign w_b_zero = (w_b == '0);

    assign st_data         = w_a;
    assign program_counter = r_pc;
    assign done            = r_done;
    assign div0            = r_div0;

    assign w_issue_long   = w_issue && ((alu_op == OP_MULT) || (alu_op == OP_DIV));
    assign w_issue_single = w_issue && !w_issue_long;

    // Shift-add step: conditionally add multiplicand, shift {hi,lo} right.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    // Restoring step: shift next dividend bit into remainder, trial subtract.
    assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
    assign w_fits   = (w_rem_sh >= {1'b0, r_opb});
    assign w_trial  = w_rem_sh[WIDTH-1:0] - r_opb;

    // Single-cycle ALU result (result1); result2 is always operand a.
    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_COPY: w_alu = w_b;
            default: w_alu = '0;
        endcase
    end

    // FSM next state and ready; a start is only accepted in IDLE.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_issue = 1'b1;
                    if (alu_op == OP_MULT) begin
                        w_state_next = S_BUSY;
                    end else if (alu_op == OP_DIV) begin
                        w_state_next = w_b_zero ? S_WB : S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_next = S_WB;
                end
            end
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Multi-cycle operand capture and one MULT/DIV iteration per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opb       <= '0;
            r_is_div    <= 1'b0;
            r_div0_pend <= 1'b0;
            r_wr        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
        end else if (w_issue_long) begin
            r_cnt       <= '0;
            r_wr        <= write;
            r_y1        <= Y1;
            r_y2        <= Y2;
            r_is_div    <= (alu_op == OP_DIV);
            r_div0_pend <= 1'b0;
            if (alu_op == OP_MULT) begin
                r_hi  <= '0;
                r_lo  <= w_b;
                r_opb <= w_a;
            end else if (w_b_zero) begin
                // Divide by zero: results are preloaded, WB follows directly.
                r_hi        <= w_a;
                r_lo        <= '1;
                r_opb       <= w_b;
                r_div0_pend <= 1'b1;
            end else begin
                r_hi  <= '0;
                r_lo  <= w_a;
                r_opb <= w_b;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                if (w_fits) begin
                    r_hi <= w_trial;
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_rem_sh[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    // Writeback source: issue edge for single-cycle ops, WB edge for MULT/DIV.
    always_comb begin
        w_we1  = 1'b0;
        w_we2  = 1'b0;
        w_wa1  = '0;
        w_wa2  = '0;
        w_res1 = '0;
        w_res2 = '0;
        if (r_state == S_WB) begin
            w_we1  = r_wr[0];
            w_we2  = r_wr[1];
            w_wa1  = r_y1;
            w_wa2  = r_y2;
            w_res1 = r_lo;
            w_res2 = r_hi;
        end else if (w_issue_single) begin
            w_we1  = write[0];
            w_we2  = write[1];
            w_wa1  = Y1;
            w_wa2  = Y2;
            w_res1 = w_alu;
            w_res2 = w_a;
        end
    end

    // Register file writes; port 2 takes priority on an address clash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_we2 && (w_wa2 == AW'(i))) begin
                    r_regs[i] <= w_res2;
                end else if (w_we1 && (w_wa1 == AW'(i))) begin
                    r_regs[i] <= w_res1;
                end
            end
        end
    end

    // done pulses the cycle after writeback; div0 accompanies it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= w_issue_single || (r_state == S_WB);
            r_div0 <= (r_state == S_WB) && r_div0_pend;
        end
    end

    // Program counter: only moves while IDLE, jump beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
        end else if (r_state == S_IDLE) begin
            if (jump) begin
                r_pc <= constant;
            end else if (pc_inc) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_datapath.sv
// tb_param_datapath: directed vector table, hand-written multi-cycle
// sequences and randomized ops against a behavioural model.
`timescale 1ns/1ps
module tb_param_datapath;
    localparam int W = 32;
    localparam int N = 16;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b100;
    localparam logic [2:0] MULT = 3'b001;
    localparam logic [2:0] DIV  = 3'b101;
    localparam logic [2:0] ANDO = 3'b010;
    localparam logic [2:0] ORO  = 3'b011;
    localparam logic [2:0] XORO = 3'b110;
    localparam logic [2:0] COPY = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   alu_op = '0;
    logic [3:0]   A = '0;
    logic [3:0]   C = '0;
    logic [3:0]   Y1 = '0;
    logic [3:0]   Y2 = '0;
    logic [1:0]   write = '0;
    logic         const_c = 1'b0;
    logic [W-1:0] constant = '0;
    logic         pc_inc = 1'b0;
    logic         jump = 1'b0;
    logic         ready;
    logic         done;
    logic         div0;
    logic [W-1:0] st_data;
    logic [W-1:0] program_counter;

    int n_err = 0;
    int n_chk = 0;

    param_datapath #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
        .A(A), .C(C), .Y1(Y1), .Y2(Y2), .write(write),
        .const_c(const_c), .constant(constant), .pc_inc(pc_inc), .jump(jump),
        .ready(ready), .done(done), .div0(div0),
        .st_data(st_data), .program_counter(program_counter)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        int           a;
        int           c;
        int           y1;
        int           y2;
        logic [1:0]   wr;
        logic         cc;
        logic [W-1:0] k;
    } op_t;

    typedef struct {
        op_t          o;
        int           ck1;
        logic [W-1:0] v1;
        int           ck2;
        logic [W-1:0] v2;
        int           lat;
        logic         d0;
    } vec_t;

    // Architectural register contents as the model sees them.
    logic [W-1:0] m [N];

    function automatic vec_t mkv(input logic [2:0] op, input int a, input int c,
                                 input int y1, input int y2, input logic [1:0] wr,
                                 input logic cc, input logic [W-1:0] k,
                                 input int ck1, input logic [W-1:0] v1,
                                 input int ck2, input logic [W-1:0] v2,
                                 input int lat, input logic d0);
        vec_t v;
        v.o.op = op; v.o.a = a; v.o.c = c; v.o.y1 = y1; v.o.y2 = y2;
        v.o.wr = wr; v.o.cc = cc; v.o.k = k;
        v.ck1 = ck1; v.v1 = v1; v.ck2 = ck2; v.v2 = v2; v.lat = lat; v.d0 = d0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_reg(input int idx, output logic [W-1:0] v);
        A = 4'(idx);
        #1;
        v = st_data;
    endtask

    // Reference: result from plain arithmetic, latency from the op class.
    task automatic model_apply(input op_t o, output int elat, output logic ed0);
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   r1;
        logic [W-1:0]   r2;
        logic [2*W-1:0] p;
        a = m[o.a];
        b = o.cc ? o.k : m[o.c];
        r1 = '0;
        r2 = a;
        ed0 = 1'b0;
        elat = 1;
        case (o.op)
            ADD:  r1 = a + b;
            SUB:  r1 = a - b;
            ANDO: r1 = a & b;
            ORO:  r1 = a | b;
            XORO: r1 = a ^ b;
            COPY: r1 = b;
            MULT: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r1 = p[W-1:0];
                r2 = p[2*W-1:W];
                elat = W + 2;
            end
            default: begin
                if (b == '0) begin
                    r1 = '1; r2 = a; ed0 = 1'b1; elat = 2;
                end else begin
                    r1 = a / b; r2 = a % b; elat = W + 2;
                end
            end
        endcase
        if (o.wr[0] && o.y1 != 0) m[o.y1] = r1;
        if (o.wr[1] && o.y2 != 0) m[o.y2] = r2;
    endtask

    // Issue one op, scramble the destination controls, wait (bounded) for done.
    task automatic run_op(input op_t o, output int lat, output logic d0,
                          output int elat, output logic ed0);
        @(negedge clk);
        alu_op = o.op; A = 4'(o.a); C = 4'(o.c); Y1 = 4'(o.y1); Y2 = 4'(o.y2);
        write = o.wr; const_c = o.cc; constant = o.k; start = 1'b1;
        model_apply(o, elat, ed0);
        @(negedge clk);
        start = 1'b0;
        write = ~o.wr;
        Y1 = 4'($urandom_range(0, 15));
        Y2 = 4'($urandom_range(0, 15));
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        d0 = div0;
        $display("op=%b A=%0d C=%0d Y1=%0d Y2=%0d wr=%b cc=%0d k=%h lat=%0d div0=%0d",
                 o.op, o.a, o.c, o.y1, o.y2, o.wr, o.cc, o.k, lat, d0);
    endtask

    vec_t tbl [19];

    initial begin
        int           lat;
        int           elat;
        logic         d0;
        logic         ed0;
        logic [W-1:0] v;
        op_t          o;
        int           nlow;
        int           pcbad;
        int           cyc;
        int           ndone;

        for (int i = 0; i < N; i++) m[i] = '0;

        tbl[0]  = mkv(COPY, 0, 0, 1, 0, 2'b01, 1, 32'd5,          1, 32'd5,          0, 32'd0,  1, 0);
        tbl[1]  = mkv(COPY, 0, 0, 2, 0, 2'b01, 1, 32'd7,          2, 32'd7,          1, 32'd5,  1, 0);
        tbl[2]  = mkv(ADD,  1, 2, 3, 0, 2'b01, 0, 32'd0,          3, 32'd12,         1, 32'd5,  1, 0);
        // result2 is operand a = reg[3] = 12, so reg[3] keeps 12
        tbl[3]  = mkv(SUB,  3, 1, 0, 3, 2'b10, 0, 32'd0,          3, 32'd12,         2, 32'd7,  1, 0);
        tbl[4]  = mkv(ANDO, 1, 2, 9, 0, 2'b01, 0, 32'd0,          9, 32'd5,          3, 32'd12, 1, 0);
        tbl[5]  = mkv(ORO,  1, 2, 10, 0, 2'b01, 0, 32'd0,        10, 32'd7,          9, 32'd5,  1, 0);
        tbl[6]  = mkv(XORO, 1, 2, 11, 0, 2'b01, 0, 32'd0,        11, 32'd2,         10, 32'd7,  1, 0);
        tbl[7]  = mkv(SUB,  0, 1, 12, 13, 2'b11, 0, 32'd0,       12, 32'hFFFFFFFB,  13, 32'd0,  1, 0);
        tbl[8]  = mkv(COPY, 0, 0, 1, 0, 2'b01, 1, 32'hFFFFFFFF,  1, 32'hFFFFFFFF,   0, 32'd0,  1, 0);
        tbl[9]  = mkv(COPY, 0, 0, 2, 0, 2'b01, 1, 32'd2,          2, 32'd2,          0, 32'd0,  1, 0);
        tbl[10] = mkv(MULT, 1, 2, 4, 5, 2'b11, 0, 32'd0,          4, 32'hFFFFFFFE,   5, 32'd1,  W + 2, 0);
        tbl[11] = mkv(COPY, 0, 0, 1, 0, 2'b01, 1, 32'd100,        1, 32'd100,        0, 32'd0,  1, 0);
        tbl[12] = mkv(DIV,  1, 0, 6, 7, 2'b11, 1, 32'd7,          6, 32'd14,         7, 32'd2,  W + 2, 0);
        tbl[13] = mkv(DIV,  1, 0, 6, 7, 2'b11, 1, 32'd0,          6, 32'hFFFFFFFF,   7, 32'd100, 2, 1);
        tbl[14] = mkv(COPY, 1, 0, 0, 0, 2'b11, 1, 32'h55,         0, 32'd0,          1, 32'd100, 1, 0);
        tbl[15] = mkv(COPY, 0, 0, 1, 0, 2'b01, 1, 32'd5,          1, 32'd5,          0, 32'd0,  1, 0);
        tbl[16] = mkv(COPY, 0, 0, 2, 0, 2'b01, 1, 32'd7,          2, 32'd7,          1, 32'd5,  1, 0);
        tbl[17] = mkv(ADD,  1, 2, 8, 8, 2'b11, 0, 32'd0,          8, 32'd5,          9, 32'd5,  1, 0);
        tbl[18] = mkv(ADD,  1, 0, 14, 0, 2'b01, 1, 32'hFFFFFFFF, 14, 32'd4,          1, 32'd5,  1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ready", ready, 1'b1);
        check("reset done", done, 1'b0);
        check("reset div0", div0, 1'b0);
        check("reset pc", program_counter, '0);
        read_reg(5, v);
        check("reset reg5", v, '0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            run_op(tbl[i].o, lat, d0, elat, ed0);
            check($sformatf("vec%0d lat", i), lat, tbl[i].lat);
            check($sformatf("vec%0d div0", i), d0, tbl[i].d0);
            read_reg(tbl[i].ck1, v);
            check($sformatf("vec%0d r%0d", i, tbl[i].ck1), v, tbl[i].v1);
            read_reg(tbl[i].ck2, v);
            check($sformatf("vec%0d r%0d", i, tbl[i].ck2), v, tbl[i].v2);
        end

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            o.op = 3'($urandom_range(0, 7));
            o.a  = $urandom_range(0, 15);
            o.c  = $urandom_range(0, 15);
            o.y1 = $urandom_range(0, 15);
            o.y2 = $urandom_range(0, 15);
            o.wr = 2'($urandom_range(0, 3));
            o.cc = 1'($urandom_range(0, 1));
            o.k  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            run_op(o, lat, d0, elat, ed0);
            check($sformatf("rnd%0d lat", i), lat, elat);
            check($sformatf("rnd%0d div0", i), d0, ed0);
            read_reg(o.y1, v);
            check($sformatf("rnd%0d r%0d", i, o.y1), v, m[o.y1]);
            read_reg(o.y2, v);
            check($sformatf("rnd%0d r%0d", i, o.y2), v, m[o.y2]);
        end
        for (int i = 0; i < N; i++) begin
            read_reg(i, v);
            check($sformatf("sweep r%0d", i), v, m[i]);
        end

        // MULT with pc_inc held: PC moves only at the issue edge, ready low WIDTH+1 cycles
        @(negedge clk);
        jump = 1'b1; constant = 32'h10;
        @(negedge clk);
        jump = 1'b0; pc_inc = 1'b1;
        alu_op = MULT; A = 4'd1; C = 4'd2; const_c = 1'b0; write = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nlow = 0; pcbad = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (ready == 1'b0) nlow++;
            if (program_counter !== 32'h11) pcbad++;
            @(negedge clk);
            cyc++;
        end
        $display("mult seq: ready low %0d cycles, done after %0d", nlow, cyc + 1);
        check("mult done lat", cyc + 1, W + 2);
        check("mult ready low", nlow, W + 1);
        check("mult pc frozen", pcbad, 0);
        check("mult pc at done", program_counter, 32'h11);
        @(negedge clk);
        check("done single pulse", done, 1'b0);
        check("pc resumes", program_counter, 32'h12);
        pc_inc = 1'b0;

        // Reset in the middle of a MULT aborts it
        @(negedge clk);
        alu_op = MULT; A = 4'd1; C = 4'd2; Y1 = 4'd13; Y2 = 4'd14; write = 2'b11;
        const_c = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("reset asserted mid-MULT");
        check("abort ready", ready, 1'b1);
        check("abort pc", program_counter, '0);
        check("abort done", done, 1'b0);
        for (int i = 0; i < N; i++) m[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort no done", ndone, 0);
        check("abort idle", ready, 1'b1);
        for (int i = 0; i < N; i++) begin
            read_reg(i, v);
            check($sformatf("abort r%0d", i), v, m[i]);
        end

        // jump has priority over pc_inc
        @(negedge clk);
        jump = 1'b1; pc_inc = 1'b1; constant = 32'h40;
        @(negedge clk);
        check("jump priority", program_counter, 32'h40);
        jump = 1'b0;
        @(negedge clk);
        check("pc increment", program_counter, 32'h41);
        pc_inc = 1'b0;
        $display("pc seq: pc=%h", program_counter);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
